// File: rtl/riscv_ctrl_pkg.sv
// Shared types and select encodings for the multi-cycle RV32I controller.
package riscv_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMREAD,
      MEMWB,
      MEMWRITE,
      EXECR,
      EXECI,
      ALUWB,
      BEQ,
      JAL,
      TRAP
   } state_t;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_RTYPE = 7'b0110011;
   localparam logic [6:0] OP_ITYPE = 7'b0010011;
   localparam logic [6:0] OP_BEQ   = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Coarse ALU request from the FSM; FUNCT defers to the instruction fields.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REG   = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   function automatic logic [1:0] immSrcOf(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_BEQ:  return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/riscv_alu_decoder.sv
// Combinational ALU control: maps the FSM's coarse ALU request plus
// instruction fields onto the 3-bit ALUControl code.
module riscv_alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic [1:0] aluOp_i,
   output logic [2:0] aluControl_o
);

   // Funct7b5 selects subtract only for register-register ops; for
   // immediates that bit belongs to the immediate value.
   always_comb begin
      aluControl_o = ALU_ADD;
      case (aluOp_i)
         ALUOP_ADD: aluControl_o = ALU_ADD;
         ALUOP_SUB: aluControl_o = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct3_i)
               3'b000:  aluControl_o = (op_i == OP_RTYPE && funct7b5_i) ? ALU_SUB : ALU_ADD;
               3'b010:  aluControl_o = ALU_SLT;
               3'b110:  aluControl_o = ALU_OR;
               3'b111:  aluControl_o = ALU_AND;
               default: aluControl_o = ALU_ADD;
            endcase
         end
         default: aluControl_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/riscv_mc_controller.sv
// Multi-cycle main control FSM for the RV32I core with a shared memory port.
// Define RV_PERF_CNT_EN to add the CycleCnt/InstrCnt performance counters.
module riscv_mc_controller
   import riscv_ctrl_pkg::*;
   #(parameter int CNT_W = 32)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] op_i,
   input  logic [2:0] funct3_i,
   input  logic       funct7b5_i,
   input  logic       zero_i,
   input  logic       memReady_i,
   output logic       memReq_o,
   output logic       memWrite_o,
   output logic       adrSrc_o,
   output logic       irWrite_o,
   output logic       pcWrite_o,
   output logic       regWrite_o,
   output logic [1:0] resultSrc_o,
   output logic [1:0] aluSrcA_o,
   output logic [1:0] aluSrcB_o,
   output logic [1:0] immSrc_o,
   output logic [2:0] aluControl_o,
   output logic       illegal_o
`ifdef RV_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycleCnt_o,
   output logic [CNT_W-1:0] instrCnt_o
`endif
);

   state_t     state_q, state_d;
   logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite, illegal;
   logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc, aluOp;
   logic [2:0] aluControl;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next state and controls; everything idles at 0 unless the state needs it.
   always_comb begin
      state_d   = state_q;
      memReq    = 1'b0;
      memWrite  = 1'b0;
      adrSrc    = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      illegal   = 1'b0;
      resultSrc = RES_ALUOUT;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_REG;
      immSrc    = IMM_I;
      aluOp     = ALUOP_ADD;
      case (state_q)
         FETCH: begin
            memReq = 1'b1;
            if (memReady_i) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               aluSrcB   = SRCB_FOUR;
               resultSrc = RES_ALURESULT;
               state_d   = DECODE;
            end
         end
         DECODE: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_IMM;
            immSrc  = immSrcOf(op_i);
            case (op_i)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECR;
               OP_ITYPE:     state_d = EXECI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default:      state_d = TRAP;
            endcase
         end
         MEMADR: begin
            aluSrcA = SRCA_REG;
            aluSrcB = SRCB_IMM;
            immSrc  = immSrcOf(op_i);
            state_d = (op_i == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            memReq = 1'b1;
            adrSrc = 1'b1;
            if (memReady_i) state_d = MEMWB;
         end
         MEMWB: begin
            resultSrc = RES_DATA;
            regWrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            memReq   = 1'b1;
            memWrite = 1'b1;
            adrSrc   = 1'b1;
            if (memReady_i) state_d = FETCH;
         end
         EXECR: begin
            aluSrcA = SRCA_REG;
            aluSrcB = SRCB_REG;
            aluOp   = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         EXECI: begin
            aluSrcA = SRCA_REG;
            aluSrcB = SRCB_IMM;
            immSrc  = immSrcOf(op_i);
            aluOp   = ALUOP_FUNCT;
            state_d = ALUWB;
         end
         ALUWB: begin
            regWrite = 1'b1;
            state_d  = FETCH;
         end
         BEQ: begin
            aluSrcA = SRCA_REG;
            aluSrcB = SRCB_REG;
            aluOp   = ALUOP_SUB;
            pcWrite = zero_i;
            state_d = FETCH;
         end
         JAL: begin
            aluSrcA = SRCA_OLDPC;
            aluSrcB = SRCB_FOUR;
            pcWrite = 1'b1;
            state_d = ALUWB;
         end
         TRAP: illegal = 1'b1;
         default: state_d = FETCH;
      endcase
   end

   riscv_alu_decoder u_aluDec (
      .op_i         (op_i),
      .funct3_i     (funct3_i),
      .funct7b5_i   (funct7b5_i),
      .aluOp_i      (aluOp),
      .aluControl_o (aluControl)
   );

   // Reset silences the datapath immediately, not just from the next edge.
   assign memReq_o     = memReq   & ~rst_i;
   assign memWrite_o   = memWrite & ~rst_i;
   assign adrSrc_o     = adrSrc   & ~rst_i;
   assign irWrite_o    = irWrite  & ~rst_i;
   assign pcWrite_o    = pcWrite  & ~rst_i;
   assign regWrite_o   = regWrite & ~rst_i;
   assign illegal_o    = illegal  & ~rst_i;
   assign resultSrc_o  = rst_i ? 2'b00  : resultSrc;
   assign aluSrcA_o    = rst_i ? 2'b00  : aluSrcA;
   assign aluSrcB_o    = rst_i ? 2'b00  : aluSrcB;
   assign immSrc_o     = rst_i ? 2'b00  : immSrc;
   assign aluControl_o = rst_i ? 3'b000 : aluControl;

`ifdef RV_PERF_CNT_EN
   logic [CNT_W-1:0] cycleCnt_q, instrCnt_q;
   logic             instrDone;

   // An instruction retires when a non-fetch state hands control back to FETCH.
   assign instrDone = (state_d == FETCH) && (state_q != FETCH);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycleCnt_q <= '0;
         instrCnt_q <= '0;
      end else begin
         cycleCnt_q <= cycleCnt_q + CNT_W'(1);
         if (instrDone) instrCnt_q <= instrCnt_q + CNT_W'(1);
      end
   end

   assign cycleCnt_o = cycleCnt_q;
   assign instrCnt_o = instrCnt_q;
`endif

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Self-checking bench for riscv_mc_controller: directed instruction table,
// reset/trap sequences and randomized instruction streams vs. a cycle-list model.
module tb_riscv_mc_controller;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [6:0] op_i = 7'd0;
   logic [2:0] funct3_i = 3'd0;
   logic       funct7b5_i = 1'b0;
   logic       zero_i = 1'b0;
   logic       memReady_i = 1'b0;
   logic       memReq_o, memWrite_o, adrSrc_o, irWrite_o, pcWrite_o, regWrite_o, illegal_o;
   logic [1:0] resultSrc_o, aluSrcA_o, aluSrcB_o, immSrc_o;
   logic [2:0] aluControl_o;
`ifdef RV_PERF_CNT_EN
   logic [31:0] cycleCnt_o, instrCnt_o;
`endif

   int checks = 0;
   int errors = 0;
   int nRw, nPw, nMw;
   int cycSinceReset = 0;
   int expInstr = 0;

   riscv_mc_controller #(.CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .funct3_i(funct3_i),
      .funct7b5_i(funct7b5_i), .zero_i(zero_i), .memReady_i(memReady_i),
      .memReq_o(memReq_o), .memWrite_o(memWrite_o), .adrSrc_o(adrSrc_o),
      .irWrite_o(irWrite_o), .pcWrite_o(pcWrite_o), .regWrite_o(regWrite_o),
      .resultSrc_o(resultSrc_o), .aluSrcA_o(aluSrcA_o), .aluSrcB_o(aluSrcB_o),
      .immSrc_o(immSrc_o), .aluControl_o(aluControl_o), .illegal_o(illegal_o)
`ifdef RV_PERF_CNT_EN
      , .cycleCnt_o(cycleCnt_o), .instrCnt_o(instrCnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   logic [17:0] dutVec;
   assign dutVec = {memReq_o, memWrite_o, adrSrc_o, irWrite_o, pcWrite_o, regWrite_o,
                    resultSrc_o, aluSrcA_o, aluSrcB_o, immSrc_o, aluControl_o, illegal_o};

   // One expected clock cycle: the inputs to present and the outputs required.
   typedef struct {
      logic [17:0] v;
      logic        chkImm;
      logic        ready;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        zero;
   } cyc_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       zero;
      int         fw;
      int         mw;
      int         expRw;
      int         expPw;
      int         expMw;
      string      name;
   } vec_t;

   cyc_t q[$];
   logic [6:0] bOp;
   logic [2:0] bF3;
   logic       bF7, bZero;

   function automatic logic [17:0] mk(input logic mr, input logic mw, input logic adr,
                                      input logic irw, input logic pcw, input logic rw,
                                      input logic [1:0] res, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic ill);
      return {mr, mw, adr, irw, pcw, rw, res, a, b, imm, alu, ill};
   endfunction

   function automatic logic [2:0] aluExpected(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7);
      case (f3)
         3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   task automatic push(input logic [17:0] v, input logic chkImm, input logic ready);
      cyc_t c;
      c.v = v; c.chkImm = chkImm; c.ready = ready;
      c.op = bOp; c.f3 = bF3; c.f7 = bF7; c.zero = bZero;
      q.push_back(c);
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expands one instruction into its expected cycle list.
   task automatic buildInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic zero, input int fw, input int mw);
      logic [1:0] imm;
      logic       chk;
      bOp = op; bF3 = f3; bF7 = f7; bZero = zero;
      for (int i = 0; i < fw; i++)
         push(mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b0);
      push(mk(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0), 1'b0, 1'b1);
      chk = 1'b1;
      case (op)
         7'b0000011, 7'b0010011: imm = 2'b00;
         7'b0100011:             imm = 2'b01;
         7'b1100011:             imm = 2'b10;
         7'b1101111:             imm = 2'b11;
         default: begin imm = 2'b00; chk = 1'b0; end
      endcase
      push(mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,imm,3'b000,0), chk, rnd());
      case (op)
         7'b0000011: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), 1'b0, rnd());
            for (int i = 0; i < mw; i++)
               push(mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b0);
            push(mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b1);
            push(mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0), 1'b0, rnd());
         end
         7'b0100011: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0), 1'b0, rnd());
            for (int i = 0; i < mw; i++)
               push(mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b0);
            push(mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, 1'b1);
         end
         7'b0110011, 7'b0010011: begin
            push(mk(0,0,0,0,0,0,2'b00,2'b10,(op == 7'b0110011) ? 2'b00 : 2'b01,2'b00,
                    aluExpected(op, f3, f7),0), 1'b0, rnd());
            push(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, rnd());
         end
         7'b1100011:
            push(mk(0,0,0,0,zero,0,2'b00,2'b10,2'b00,2'b00,3'b001,0), 1'b0, rnd());
         7'b1101111: begin
            push(mk(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b00,3'b000,0), 1'b0, rnd());
            push(mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b0, rnd());
         end
         default:
            for (int i = 0; i < 10; i++)
               push(mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1), 1'b0, rnd());
      endcase
   endtask

   task automatic checkOutput(input string name, input logic [17:0] exp, input logic chkImm);
      logic [17:0] mask;
      mask = chkImm ? 18'h3FFFF : 18'h3FFCF;
      checks++;
      if ((dutVec & mask) !== (exp & mask)) begin
         errors++;
         $display("[TB] FAIL %s: outputs got %h required %h (mask %h)", name, dutVec & mask,
                  exp & mask, mask);
      end
   endtask

   task automatic checkCounters(input string name);
`ifdef RV_PERF_CNT_EN
      checks++;
      if (cycleCnt_o !== 32'(cycSinceReset)) begin
         errors++;
         $display("[TB] FAIL %s_cycleCnt: got %0d required %0d", name, cycleCnt_o, cycSinceReset);
      end
      checks++;
      if (instrCnt_o !== 32'(expInstr)) begin
         errors++;
         $display("[TB] FAIL %s_instrCnt: got %0d required %0d", name, instrCnt_o, expInstr);
      end
`else
      if (name.len() < 0) $display("[TB] %s", name);
`endif
   endtask

   task automatic applyStimulus(input cyc_t c, input string name);
      @(negedge clk_i);
      memReady_i = c.ready;
      op_i       = c.op;
      funct3_i   = c.f3;
      funct7b5_i = c.f7;
      zero_i     = c.zero;
      #1;
      checkOutput(name, c.v, c.chkImm);
      checkCounters(name);
      if (regWrite_o) nRw++;
      if (pcWrite_o)  nPw++;
      if (memWrite_o) nMw++;
      cycSinceReset++;
   endtask

   // Runs the first n cycles of the built list (all of it when n < 0).
   task automatic runQueue(input string name, input int n);
      int lim;
      lim = (n < 0) ? q.size() : n;
      nRw = 0; nPw = 0; nMw = 0;
      for (int i = 0; i < lim; i++)
         applyStimulus(q[i], $sformatf("%s_c%0d", name, i));
   endtask

   task automatic runInstr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic zero, input int fw, input int mw, input string name);
      q.delete();
      buildInstr(op, f3, f7, zero, fw, mw);
      runQueue(name, -1);
      if (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})
         expInstr++;
   endtask

   task automatic releaseReset(input string name);
      @(negedge clk_i);
      rst_i = 1'b0;
      memReady_i = 1'b0;
      #1;
      checkOutput({name, "_fetch"}, mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0), 1'b1);
      checkCounters(name);
      cycSinceReset++;
   endtask

   task automatic doReset(input string name);
      @(negedge clk_i);
      rst_i = 1'b1;
      memReady_i = 1'b0;
      cycSinceReset = 0;
      expInstr = 0;
      #1;
      checkOutput({name, "_async"}, 18'h0, 1'b1);
      checkCounters({name, "_async"});
      @(negedge clk_i);
      memReady_i = 1'b1;
      #1;
      checkOutput({name, "_held"}, 18'h0, 1'b1);
      checkCounters({name, "_held"});
      releaseReset(name);
   endtask

   vec_t tbl[12];

   initial begin
      tbl[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 1, 1, 0, "lw"};
      tbl[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, 0, 1, 4, "sw_wait3"};
      tbl[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 1, 1, 0, "r_sub"};
      tbl[3]  = '{7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 1, 1, 0, "i_add"};
      tbl[4]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 0, 2, 0, "beq_taken"};
      tbl[5]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, 0, 1, 0, "beq_not"};
      tbl[6]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 1, 2, 0, "jal"};
      tbl[7]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 2, 0, 1, 1, 0, "r_slt_fw2"};
      tbl[8]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 1, 1, 0, "i_or"};
      tbl[9]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 1, 1, 0, "r_and"};
      tbl[10] = '{7'b0000011, 3'b010, 1'b0, 1'b0, 1, 2, 1, 1, 0, "lw_wait"};
      tbl[11] = '{7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 0, 1, 1, "sw"};

      @(negedge clk_i);
      #1;
      checkOutput("reset_outputs", 18'h0, 1'b1);
      cycSinceReset = 0;
      expInstr = 0;
      checkCounters("reset_counters");
      releaseReset("reset_release");

      for (int i = 0; i < $size(tbl); i++) begin
         runInstr(tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].zero, tbl[i].fw, tbl[i].mw,
                  tbl[i].name);
         checks++;
         if (nRw != tbl[i].expRw || nPw != tbl[i].expPw || nMw != tbl[i].expMw) begin
            errors++;
            $display("[TB] FAIL %s_strobes: regWrite/pcWrite/memWrite cycles got %0d/%0d/%0d required %0d/%0d/%0d",
                     tbl[i].name, nRw, nPw, nMw, tbl[i].expRw, tbl[i].expPw, tbl[i].expMw);
         end
      end

      // Reset in the middle of a stalled load read.
      q.delete();
      buildInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 5);
      runQueue("lw_pre_reset", 5);
      doReset("reset_memread");
      runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, "lw_after_reset");

      for (int n = 0; n < 120; n++) begin
         logic [6:0] ops[6];
         int k;
         ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
         k = $urandom_range(0, 5);
         runInstr(ops[k], 3'($urandom_range(0, 7)), rnd(), rnd(),
                  $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d", n));
      end

      // Unsupported opcode: trap holds Illegal and freezes retirement.
      runInstr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, 0, "trap");
      doReset("reset_trap");
      runInstr(7'b0010011, 3'b111, 1'b0, 1'b0, 0, 0, "i_and_after_trap");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
